// File: rtl/program_loader.sv
// program_loader: turns a length-prefixed byte stream into ROM byte writes and holds the CPU in reset until the load is done.
// Optional trailing XOR checksum byte is compiled in by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDRESS_WIDTH           = 32,
    parameter int DATA_WIDTH              = 8,
    parameter int ADDRESS_AVAILABLE_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     restart,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error,
    output logic [2:0]               state_dbg
);

    localparam int          CW       = ADDRESS_AVAILABLE_WIDTH + 1;
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDRESS_AVAILABLE_WIDTH);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM   = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = S_CSUM;
`else
    localparam state_t PAYLOAD_END = S_DONE;
`endif

    state_t                   state_q, state_d;
    logic [7:0]               len_lo_q;
    logic [15:0]              len_full;
    logic [CW-1:0]            len_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_next;
    logic                     len_over;
    logic                     len_zero;
    logic                     last_byte;
    logic                     accept;
    logic                     wr_en_q;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]    wr_data_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    csum_q;
    logic                     csum_ok;
`endif

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on the state, never on in_valid, and in_data is ignored otherwise.
    assign accept     = in_valid && in_ready;
    assign len_full   = {in_data[7:0], len_lo_q};
    assign len_over   = {1'b0, len_full} > CAPACITY;
    assign len_zero   = (len_full == 16'd0);
    assign count_next = count_q + CW'(1);
    assign last_byte  = (count_next == len_q);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign csum_ok    = ((csum_q ^ in_data) == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_over)      state_d = S_ERR;
                    else if (len_zero) state_d = PAYLOAD_END;
                    else               state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && last_byte) state_d = PAYLOAD_END;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_d = csum_ok ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (restart) state_d = S_LEN_LO;
            end
            default: state_d = S_LEN_LO;
        endcase
    end

    // Write port is registered: one strobe exactly one cycle after each payload accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo_q  <= '0;
            len_q     <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_LEN_LO: begin
                    if (accept) len_lo_q <= in_data[7:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_q <= '0;
`endif
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_q   <= len_full[CW-1:0];
                        count_q <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {{(ADDRESS_WIDTH-CW){1'b0}}, count_q};
                        wr_data_q <= in_data;
                        count_q   <= count_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_q    <= csum_q ^ in_data;
`endif
                    end
                end
                S_DONE, S_ERR: begin
                    if (restart) begin
                        count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // done waits out the final write strobe so the CPU never leaves reset before its last byte lands.
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = (state_q == S_DONE) && !wr_en_q;
    assign cpu_hold  = !done;
    assign error     = (state_q == S_ERR);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: vector table, hand sequences and random loads checked every cycle
// against a model derived from the history of accepted stream bytes.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int CAP = 4096;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        restart = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  program_loader #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(8),
    .ADDRESS_AVAILABLE_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: everything follows from the bytes accepted since the last (re)start.
  logic [7:0]  acc_q[$];
  logic [7:0]  exp_q[$];
  logic        wr_pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [7:0]  pend_data = 8'h00;
  logic [31:0] last_addr = 32'h0;
  logic [7:0]  last_data = 8'h00;
  logic        mon_en = 1'b0;
  logic [7:0]  rom [CAP];
  int          load_writes = 0;
  logic [31:0] last_wr_seen = 32'h0;

  function automatic void model_status(output bit dn, output bit er);
    int n;
    int len;
    logic [7:0] x;
    dn = 1'b0;
    er = 1'b0;
    n = acc_q.size();
    if (n < 2) return;
    len = int'(acc_q[1]) * 256 + int'(acc_q[0]);
    if (len > CAP) begin
      er = 1'b1;
      return;
    end
    if (n < 2 + len + CS) return;
    if (CS != 0) begin
      x = 8'h00;
      for (int i = 2; i < n; i++) x = x ^ acc_q[i];
      if (x == 8'h00) dn = 1'b1;
      else            er = 1'b1;
    end else begin
      dn = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      bit dn;
      bit er;
      int idx;
      int len;
      model_status(dn, er);
      chk1("wr_en", wr_en, wr_pend);
      if (wr_pend) begin
        chk32("wr_addr", wr_addr, pend_addr);
        chk32("wr_data", 32'(wr_data), 32'(pend_data));
      end else begin
        chk32("wr_addr_hold", wr_addr, last_addr);
        chk32("wr_data_hold", 32'(wr_data), 32'(last_data));
      end
      chk1("in_ready", in_ready, !(dn || er));
      chk1("done", done, dn && !wr_pend);
      chk1("error", error, er);
      chk1("cpu_hold", cpu_hold, !(dn && !wr_pend));
      if (wr_en) begin
        rom[wr_addr[11:0]] = wr_data;
        load_writes++;
        last_wr_seen = wr_addr;
      end
      if (rst) begin
        acc_q.delete();
        wr_pend = 1'b0;
        last_addr = 32'h0;
        last_data = 8'h00;
      end else begin
        if (wr_pend) begin
          last_addr = pend_addr;
          last_data = pend_data;
        end
        wr_pend = 1'b0;
        if (in_valid && !(dn || er)) begin
          idx = acc_q.size();
          if (idx >= 2) begin
            len = int'(acc_q[1]) * 256 + int'(acc_q[0]);
            if (idx < 2 + len) begin
              wr_pend = 1'b1;
              pend_addr = 32'(idx - 2);
              pend_data = in_data;
            end
          end
          acc_q.push_back(in_data);
        end else if (restart && (dn || er)) begin
          acc_q.delete();
        end
      end
    end
  end

  // Driver tasks: each starts and ends 1 ns after a rising edge.
  logic [7:0] stream_q[$];

  task automatic send_byte(input logic [7:0] b, input bit rs);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = b;
    restart = rs;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 40) begin
        chk1("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    restart = 1'b0;
    in_data = 8'($urandom_range(0, 255));
  endtask

  task automatic send_stream(input int gap, input bit rand_gap);
    int g;
    for (int i = 0; i < stream_q.size(); i++) begin
      send_byte(stream_q[i], rand_gap && ($urandom_range(0, 7) == 0));
      g = rand_gap ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_status(input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (!(done || error) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!(done || error)) chk1("status_timeout", 1'b0, 1'b1);
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < CAP; i++) rom[i] = 8'h00;
    load_writes = 0;
  endtask

  typedef struct packed {
    logic [63:0] bytes;
    logic [3:0]  n;
    logic [1:0]  gap;
    logic        exp_done;
    logic        exp_err;
    logic [12:0] exp_writes;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  function automatic void set_vec(input int i, input logic [63:0] b, input int n, input int gap,
                                  input bit d, input bit e, input int w, input logic [31:0] word);
    vecs[i].bytes = b;
    vecs[i].n = 4'(n);
    vecs[i].gap = 2'(gap);
    vecs[i].exp_done = d;
    vecs[i].exp_err = e;
    vecs[i].exp_writes = 13'(w);
    vecs[i].exp_word = word;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $finish;
  end

  initial begin
    logic [63:0] tmp;
    logic [7:0]  x;
    logic [31:0] word;

    set_vec(0, 64'h00B600A005130004, 6 + CS, 0, 1'b1, 1'b0, 4, 32'h00A00513);
    set_vec(1, 64'h00B600A005130004, 6 + CS, 1, 1'b1, 1'b0, 4, 32'h00A00513);
    set_vec(2, 64'h0000000000001001, 2, 0, 1'b0, 1'b1, 0, 32'h0);
    set_vec(3, 64'h0000000000000000, 2 + CS, 0, 1'b1, 1'b0, 0, 32'h0);
    set_vec(4, 64'h000000FF55AA0002, 4 + CS, 1, 1'b1, 1'b0, 2, 32'h000055AA);
    if (CS != 0) set_vec(5, 64'h0000000055AA0002, 5, 0, 1'b0, 1'b1, 2, 32'h000055AA);
    else         set_vec(5, 64'h00000000007E0001, 3, 2, 1'b1, 1'b0, 1, 32'h0000007E);
    set_vec(6, 64'h0000003322110003, 5 + CS, 2, 1'b1, 1'b0, 3, 32'h00332211);

    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    chk32("rst_state", 32'(state_dbg), 32'd0);
    chk1("rst_wr_en", wr_en, 1'b0);
    chk32("rst_wr_addr", wr_addr, 32'd0);
    chk32("rst_wr_data", 32'(wr_data), 32'd0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_cpu_hold", cpu_hold, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      restart_pulse();
      clear_rom();
      stream_q.delete();
      tmp = vecs[v].bytes;
      for (int i = 0; i < int'(vecs[v].n); i++) stream_q.push_back(tmp[8*i +: 8]);
      send_stream(int'(vecs[v].gap), 1'b0);
      wait_status(10);
      chk1($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
      chk1($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
      chk1($sformatf("vec%0d_cpu_hold", v), cpu_hold, !vecs[v].exp_done);
      chk1($sformatf("vec%0d_in_ready", v), in_ready, 1'b0);
      chk32($sformatf("vec%0d_writes", v), 32'(load_writes), 32'(vecs[v].exp_writes));
      word = {rom[3], rom[2], rom[1], rom[0]};
      chk32($sformatf("vec%0d_word0", v), word, vecs[v].exp_word);
      @(posedge clk); #1;
    end

    // Extra bytes after DONE must be refused and must not write.
    restart_pulse();
    clear_rom();
    stream_q = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    if (CS != 0) stream_q.push_back(8'hB6);
    send_stream(0, 1'b0);
    wait_status(10);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk32("extra_writes", 32'(load_writes), 32'd4);
    chk1("extra_done", done, 1'b1);
    @(posedge clk); #1;

    // Oversize length then restart clears error.
    restart_pulse();
    clear_rom();
    stream_q = '{8'h01, 8'h10};
    send_stream(0, 1'b0);
    wait_status(10);
    chk1("over_error", error, 1'b1);
    chk1("over_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    restart_pulse();
    @(negedge clk);
    chk1("over_restart_error", error, 1'b0);
    chk1("over_restart_in_ready", in_ready, 1'b1);
    chk32("over_restart_state", 32'(state_dbg), 32'd0);
    chk32("over_writes", 32'(load_writes), 32'd0);
    @(posedge clk); #1;

    // Reset after two of four payload bytes, then a full reload.
    clear_rom();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk32("midrst_state", 32'(state_dbg), 32'd0);
    chk1("midrst_wr_en", wr_en, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_cpu_hold", cpu_hold, 1'b1);
    chk32("midrst_writes", 32'(load_writes), 32'd2);
    @(posedge clk); #1;
    clear_rom();
    stream_q = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    if (CS != 0) stream_q.push_back(8'hB6);
    send_stream(1, 1'b0);
    wait_status(10);
    chk1("midrst_reload_done", done, 1'b1);
    word = {rom[3], rom[2], rom[1], rom[0]};
    chk32("midrst_reload_word0", word, 32'h00A00513);
    @(posedge clk); #1;

    // Full-capacity load with random payload and random source gaps.
    restart_pulse();
    clear_rom();
    exp_q.delete();
    stream_q = '{8'h00, 8'h10};
    x = 8'h00;
    for (int i = 0; i < CAP; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      stream_q.push_back(exp_q[i]);
      x = x ^ exp_q[i];
    end
    if (CS != 0) stream_q.push_back(x);
    send_stream(0, 1'b1);
    wait_status(10);
    chk1("cap_done", done, 1'b1);
    chk32("cap_writes", 32'(load_writes), 32'd4096);
    chk32("cap_last_addr", last_wr_seen, 32'd4095);
    for (int i = 0; i < CAP; i++) chk32("cap_rom", 32'(rom[i]), 32'(exp_q[i]));
    @(posedge clk); #1;

    // Random loads: short payloads, occasional oversize, occasional bad checksum.
    for (int r = 0; r < 20; r++) begin
      int  len;
      bit  over;
      bit  bad;
      restart_pulse();
      clear_rom();
      stream_q.delete();
      exp_q.delete();
      bad = 1'b0;
      over = ($urandom_range(0, 5) == 0);
      len = over ? int'($urandom_range(4097, 65535)) : int'($urandom_range(1, 48));
      stream_q.push_back(len[7:0]);
      stream_q.push_back(len[15:8]);
      if (!over) begin
        x = 8'h00;
        for (int i = 0; i < len; i++) begin
          exp_q.push_back(8'($urandom_range(0, 255)));
          stream_q.push_back(exp_q[i]);
          x = x ^ exp_q[i];
        end
        if (CS != 0) begin
          bad = ($urandom_range(0, 3) == 0);
          stream_q.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
        end
      end
      send_stream(0, 1'b1);
      wait_status(10);
      chk1($sformatf("rnd%0d_done", r), done, !(over || bad));
      chk1($sformatf("rnd%0d_error", r), error, over || bad);
      chk32($sformatf("rnd%0d_writes", r), 32'(load_writes), over ? 32'd0 : 32'(len));
      for (int i = 0; i < exp_q.size(); i++)
        chk32($sformatf("rnd%0d_rom", r), 32'(rom[i]), 32'(exp_q[i]));
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream writer that fills the byte-wide instruction ROM array before the CPU runs; the runtime alternative to `$readmemh`.
- Accepts a length-prefixed byte stream over a valid/ready handshake, e.g. from a UART receiver.
- Drives a registered byte write port into the ROM array and holds the CPU in reset until the load completes.
- Bytes land at consecutive addresses from 0, so a 32-bit word reads back little-endian `{A+3, A+2, A+1, A}`.

Parameters:
- ADDRESS_WIDTH, 32, width of `wr_addr` (matches instruction fetch address width).
- DATA_WIDTH, 8, width of `in_data` and `wr_data` (one ROM array entry).
- ADDRESS_AVAILABLE_WIDTH, 12, log2 of ROM capacity in bytes; capacity = 4096.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  stream byte valid.
- in_ready  output  1  loader can accept a byte.
- in_data  input  DATA_WIDTH  stream byte.
- restart  input  1  single-cycle pulse; re-arms the loader from DONE or ERR.
- wr_en  output  1  byte write strobe to the ROM array.
- wr_addr  output  ADDRESS_WIDTH  byte address of the write.
- wr_data  output  DATA_WIDTH  byte to write.
- cpu_hold  output  1  high holds the CPU in reset.
- done  output  1  load completed successfully.
- error  output  1  load aborted.

Behaviour:
- Reset: synchronous, active-high on `clk`. All state and counters clear; state = LEN_LO.
  - Outputs after reset: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `done=0`, `error=0`, `cpu_hold=1`, `in_ready=1`.
- Handshake: a byte is accepted in a cycle where `in_valid && in_ready`.
  - `in_ready` is combinational from state: 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 in DONE and ERR.
  - `in_data` is ignored when no handshake occurs.
- Stream format: `len[7:0]`, `len[15:8]`, then `len` payload bytes, then the checksum byte (CSUM state only with `CHECKSUM_EN`).
- States:
  - LEN_LO: on accept, store the low length byte → LEN_HI.
  - LEN_HI: on accept, form the 16-bit length N.
    - N > 2**ADDRESS_AVAILABLE_WIDTH → ERR.
    - N == 0 → CSUM if `CHECKSUM_EN`, else DONE.
    - otherwise clear the byte counter → DATA.
  - DATA: on accept, register `wr_en=1`, `wr_addr=count`, `wr_data=in_data` for exactly the next cycle; increment count.
    - The accept of byte N-1 transitions to CSUM or DONE.
  - CSUM: on accept, if (running XOR of payload) ^ `in_data` == 0 → DONE, else ERR.
  - DONE: `done=1`, `cpu_hold=0`.
  - ERR: `error=1`, `cpu_hold=1`.
  - `restart` in DONE or ERR → LEN_LO, clearing count, checksum, `done` and `error`. `restart` in any other state is ignored.
- Write latency: exactly 1 cycle from accept to `wr_en`. `wr_en` is 0 in every other cycle. Back-to-back accepts give back-to-back writes.
- `wr_addr` zero-extends the counter to ADDRESS_WIDTH. It holds its last value when `wr_en=0`.
- Byte counter width is ADDRESS_AVAILABLE_WIDTH+1, so N = 4096 is legal. Final write address = 4095; no wrap.
- `done` and the `cpu_hold` deassertion appear in the cycle after the final payload write strobe (or the checksum accept), never before the last write.
- `cpu_hold=1` in every state except DONE.
- Reset mid-load: returns to LEN_LO. Already-written bytes are not cleared and no further write is issued.

Optional Feature:
- Macro: `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined:
  - CSUM state exists and the loader expects one trailing byte.
  - The 8-bit running XOR of payload bytes resets at LEN_LO.
  - A mismatch → ERR. The payload bytes stay written, but `cpu_hold` stays 1.
- Undefined:
  - No CSUM state and no checksum register.
  - After the final payload accept the loader goes directly to DONE; any extra byte sees `in_ready=0`.

Test Plan:
- Basic load: `in_valid` held 1; stream 04 00 13 05 A0 00 (+ checksum B6 if enabled) → writes at addresses 0..3 of 13, 05, A0, 00 on consecutive cycles, each 1 cycle after its accept. `done=1`, `cpu_hold=0`; the word at address 0 reads 0x00A00513.
- Throttled source: same stream with `in_valid` toggling 1,0,1,0 → `wr_en` pulses only after accepts, the same 4 writes in the same order, no duplicates.
- Oversize: length bytes 01 10 (N = 4097) → ERR after the second accept, `error=1`, `in_ready=0`, no `wr_en` ever. A `restart` pulse → LEN_LO with `error=0`.
- Zero length and capacity edge: 00 00 → DONE with no writes. 00 10 with 4096 bytes → last write at `wr_addr`=4095, then `done=1`.
- Checksum (macro defined): 02 00 AA 55 FF → DONE. 02 00 AA 55 00 → ERR, `cpu_hold=1`, addresses 0,1 still written AA, 55.
- Reset mid-load: `rst` asserted after 2 of 4 payload bytes → next cycle state LEN_LO, `wr_en=0`, `done=0`, `cpu_hold=1`; a new full stream then loads correctly.
